// File: rtl/lm_sm_sequencer.sv
// lm_sm_sequencer
//   Memory-stage sequencer for load-multiple (LM) and store-multiple (SM).
//   The sequencer walks an 8-bit register mask in ascending order and moves
//   one word per set bit. Word addresses start at base_addr and step by 2
//   bytes, wrapping modulo 2^16.
//
// Ports
//   clk, rst         rising-edge clock, synchronous active-high reset
//   start            request pulse, sampled only while idle
//   op_sm            1 = store regs to memory, 0 = load memory into regs
//   base_addr        byte address of the first word
//   reg_mask         bit i set => register Ri is transferred
//   rf_rd_addr/data  register-file read port (SM source)
//   rf_wr_en/addr/data  register-file write port (LM destination)
//   mem_add          data-memory byte address
//   mem_din/mem_en   data-memory write data / write enable (SM)
//   mem_dout         data-memory combinational read data (LM source)
//   busy             high during RUN and DONE
//   done             one-cycle completion pulse
module lm_sm_sequencer #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int NREGS     = 8,
  parameter int ADDR_STEP = 2,
  localparam int IDX_W    = $clog2(NREGS),
  localparam int CNT_W    = $clog2(NREGS) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              op_sm,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [NREGS-1:0]  reg_mask,
  input  logic [DATA_W-1:0] rf_rd_data,
  output logic [IDX_W-1:0]  rf_rd_addr,
  output logic              rf_wr_en,
  output logic [IDX_W-1:0]  rf_wr_addr,
  output logic [DATA_W-1:0] rf_wr_data,
  output logic [ADDR_W-1:0] mem_add,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_en,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             state_reg;
  logic [NREGS-1:0]   mask_reg;
  logic [ADDR_W-1:0]  base_reg;
  logic               op_reg;
  logic [CNT_W-1:0]   count_reg;
  logic [IDX_W-1:0]   idx_reg;
  logic [ADDR_W-1:0]  mem_add_reg;
  logic               mem_en_reg;
  logic               rf_wr_en_reg;
  logic               busy_reg;
  logic               done_reg;

  logic [NREGS-1:0]   mask_next;
  logic [CNT_W-1:0]   count_next;
  logic [ADDR_W-1:0]  addr_next;

  // Index of the lowest set bit; scanning downward lets the lowest win.
  function automatic logic [IDX_W-1:0] lowest_set(input logic [NREGS-1:0] m);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int k = NREGS - 1; k >= 0; k--) begin
      if (m[k]) r = IDX_W'(k);
    end
    return r;
  endfunction

  // Remaining mask once the register currently being moved is retired.
  generate
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_mask_next
      assign mask_next[gi] = mask_reg[gi] & (idx_reg != IDX_W'(gi));
    end
  endgenerate

  assign count_next = count_reg + CNT_W'(1);
  // Address of the next word; 16-bit arithmetic so the carry drops out.
  assign addr_next  = base_reg + ADDR_W'(ADDR_STEP) * ADDR_W'(count_next);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      mask_reg     <= '0;
      base_reg     <= '0;
      op_reg       <= 1'b0;
      count_reg    <= '0;
      idx_reg      <= '0;
      mem_add_reg  <= '0;
      mem_en_reg   <= 1'b0;
      rf_wr_en_reg <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            op_reg    <= op_sm;
            base_reg  <= base_addr;
            mask_reg  <= reg_mask;
            count_reg <= '0;
            busy_reg  <= 1'b1;
            if (reg_mask == '0) begin
              state_reg <= S_DONE;
              done_reg  <= 1'b1;
            end else begin
              state_reg    <= S_RUN;
              idx_reg      <= lowest_set(reg_mask);
              mem_add_reg  <= base_addr;
              mem_en_reg   <= op_sm;
              rf_wr_en_reg <= ~op_sm;
            end
          end
        end
        S_RUN: begin
          mask_reg  <= mask_next;
          count_reg <= count_next;
          if (mask_next == '0) begin
            state_reg    <= S_DONE;
            done_reg     <= 1'b1;
            idx_reg      <= '0;
            mem_add_reg  <= '0;
            mem_en_reg   <= 1'b0;
            rf_wr_en_reg <= 1'b0;
          end else begin
            idx_reg      <= lowest_set(mask_next);
            mem_add_reg  <= addr_next;
            mem_en_reg   <= op_reg;
            rf_wr_en_reg <= ~op_reg;
          end
        end
        S_DONE: begin
          state_reg <= S_IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  // Data paths are pass-through in the transfer cycle; everything else is
  // forced to zero whenever its strobe is low.
  assign mem_add    = mem_add_reg;
  assign mem_en     = mem_en_reg;
  assign rf_wr_en   = rf_wr_en_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;
  assign rf_rd_addr = mem_en_reg   ? idx_reg    : '0;
  assign mem_din    = mem_en_reg   ? rf_rd_data : '0;
  assign rf_wr_addr = rf_wr_en_reg ? idx_reg    : '0;
  assign rf_wr_data = rf_wr_en_reg ? mem_dout   : '0;

endmodule
